// File: rtl/delta_channel_scheduler.sv
// Delta-modulation spike scheduler: NCH one-entry sample buffers share a single
// compare datapath through a round-robin arbiter; events leave via valid/ready.
module delta_channel_scheduler #(
   parameter int unsigned NCH = 4,
   parameter int unsigned DW  = 4,
   parameter int unsigned CHW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [NCH-1:0]    in_valid,
   input  logic [NCH*DW-1:0] in_data,
   output logic [NCH-1:0]    in_ready,
   input  logic [DW-1:0]     threshold,
   input  logic              emit_zero,
   input  logic              clear_prev,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CHW-1:0]    evt_ch,
   output logic [1:0]        evt_spike
);

   typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_EMIT} state_t;

   state_t           r_state;
   logic [NCH-1:0]   r_pending;
   logic [DW-1:0]    r_data [NCH];
   logic [DW-1:0]    r_prev [NCH];
   logic [CHW-1:0]   r_rr;
   logic [CHW-1:0]   r_grant;
   logic             r_evt_valid;
   logic [CHW-1:0]   r_evt_ch;
   logic [1:0]       r_evt_spike;

   logic             w_any;
   logic [CHW-1:0]   w_pick;
   int unsigned      w_idx;
   logic [DW-1:0]    w_cur;
   logic [DW-1:0]    w_old;
   logic [DW:0]      w_up_diff;
   logic [DW:0]      w_dn_diff;
   logic             w_up;
   logic             w_dn;
   logic [CHW-1:0]   w_rr_next;

   // Scan from the round-robin pointer upward, wrapping; first pending wins.
   always_comb begin
      w_any  = 1'b0;
      w_pick = '0;
      w_idx  = 0;
      for (int unsigned k = 0; k < NCH; k++) begin
         w_idx = (32'(r_rr) + k) % NCH;
         if (!w_any && r_pending[w_idx[CHW-1:0]]) begin
            w_any  = 1'b1;
            w_pick = w_idx[CHW-1:0];
         end
      end
   end

   always_comb begin
      w_cur     = r_data[r_grant];
      w_old     = r_prev[r_grant];
      w_up_diff = {1'b0, w_cur} - {1'b0, w_old};
      w_dn_diff = {1'b0, w_old} - {1'b0, w_cur};
      w_up      = (w_cur > w_old) && (w_up_diff >= {1'b0, threshold});
      w_dn      = (w_old > w_cur) && (w_dn_diff >= {1'b0, threshold});
      w_rr_next = (32'(r_grant) == NCH - 1) ? '0 : r_grant + CHW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pending   <= '0;
         r_rr        <= '0;
         r_grant     <= '0;
         r_evt_valid <= 1'b0;
         r_evt_ch    <= '0;
         r_evt_spike <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            r_data[i] <= '0;
            r_prev[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (in_valid[i] && !r_pending[i]) begin
               r_data[i]    <= in_data[i*DW +: DW];
               r_pending[i] <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (ena && w_any) begin
                  r_grant <= w_pick;
                  r_state <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               r_pending[r_grant] <= 1'b0;
               r_rr               <= w_rr_next;
               // Sub-threshold deltas leave prev alone so they accumulate.
               if (w_up || w_dn) r_prev[r_grant] <= w_cur;
               if (w_up || w_dn || emit_zero) begin
                  r_evt_ch    <= r_grant;
                  r_evt_spike <= {w_up, w_dn};
                  r_evt_valid <= 1'b1;
                  r_state     <= S_EMIT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_EMIT: begin
               if (evt_ready) begin
                  r_evt_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Placed after the COMPUTE update so a coinciding clear takes priority.
         if (clear_prev) begin
            for (int unsigned i = 0; i < NCH; i++) r_prev[i] <= '0;
         end
      end
   end

   assign in_ready  = ~r_pending;
   assign evt_valid = r_evt_valid;
   assign evt_ch    = r_evt_ch;
   assign evt_spike = r_evt_spike;

endmodule

// File: tb/tb_delta_channel_scheduler.sv
// Directed bench for delta_channel_scheduler (NCH=4, DW=4) with hand-computed
// expectations for spikes, arbitration order, stalls, clear_prev and reset.
module tb_delta_channel_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic [3:0]  in_valid;
   logic [15:0] in_data;
   logic [3:0]  in_ready;
   logic [3:0]  threshold;
   logic        emit_zero;
   logic        clear_prev;
   logic        evt_valid;
   logic        evt_ready;
   logic [1:0]  evt_ch;
   logic [1:0]  evt_spike;

   int n_total = 0;
   int n_bad   = 0;

   delta_channel_scheduler #(.NCH(4), .DW(4), .CHW(2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .threshold  (threshold),
      .emit_zero  (emit_zero),
      .clear_prev (clear_prev),
      .evt_valid  (evt_valid),
      .evt_ready  (evt_ready),
      .evt_ch     (evt_ch),
      .evt_spike  (evt_spike)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input logic [3:0] d);
      int n;
      n = 0;
      while (!in_ready[ch] && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("send_ready_timeout", 32'd1, 32'd0);
      in_data[ch*4 +: 4] = d;
      in_valid = 4'(1 << ch);
      tick();
      in_valid = '0;
   endtask

   task automatic wait_evt(input string tag);
      int n;
      n = 0;
      while (!evt_valid && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   task automatic expect_evt(input string tag, input logic [1:0] ch, input logic [1:0] sp);
      wait_evt(tag);
      chk({tag, "_ch"}, 32'(evt_ch), 32'(ch));
      chk({tag, "_spike"}, 32'(evt_spike), 32'(sp));
      tick();
   endtask

   task automatic no_evt(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         if (evt_valid) seen = 1'b1;
         tick();
      end
      chk(tag, 32'(seen), 32'd0);
   endtask

   logic [1:0] held_ch;
   logic [1:0] held_sp;

   initial begin
      rst_n = 1'b0; ena = 1'b1; in_valid = '0; in_data = '0;
      threshold = 4'd3; emit_zero = 1'b0; clear_prev = 1'b0; evt_ready = 1'b1;
      #22;
      chk("rst_in_ready",  32'(in_ready),  32'hF);
      chk("rst_evt_valid", 32'(evt_valid), 32'd0);
      chk("rst_evt_ch",    32'(evt_ch),    32'd0);
      chk("rst_evt_spike", 32'(evt_spike), 32'd0);
      rst_n = 1'b1;
      tick();

      // basic up / accumulate / down on ch0, threshold 3
      send(0, 4'd5);
      chk("lat_cap",  32'(evt_valid), 32'd0);
      tick();
      chk("lat_c1",   32'(evt_valid), 32'd0);
      tick();
      chk("lat_c2",   32'(evt_valid), 32'd1);
      chk("t1_ch",    32'(evt_ch),    32'd0);
      chk("t1_spike", 32'(evt_spike), 32'b10);
      tick();
      send(0, 4'd6);
      no_evt("t1_small_delta", 6);
      send(0, 4'd2);
      expect_evt("t1_down", 2'd0, 2'b01);

      // all four channels at once from a fresh reset
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      threshold = 4'd1;
      in_data   = 16'hFFFF;
      in_valid  = 4'hF;
      tick();
      in_valid  = '0;
      for (int k = 0; k < 4; k++) begin
         wait_evt("t2_rr");
         chk("t2_ch",    32'(evt_ch),    32'(k));
         chk("t2_spike", 32'(evt_spike), 32'b10);
         chk("t2_ready", 32'(in_ready),  32'((1 << (k + 1)) - 1));
         tick();
      end
      // ch2 moves the pointer to 3, so ch3 must beat ch1
      send(2, 4'd0);
      expect_evt("t2_ch2", 2'd2, 2'b01);
      in_data  = 16'h0000;
      in_valid = 4'b1010;
      tick();
      in_valid = '0;
      expect_evt("t2_wrap_a", 2'd3, 2'b01);
      expect_evt("t2_wrap_b", 2'd1, 2'b01);

      // consumer stall
      evt_ready = 1'b0;
      send(0, 4'd0);
      wait_evt("t3_first");
      held_ch = evt_ch;
      held_sp = evt_spike;
      chk("t3_ch",    32'(held_ch), 32'd0);
      chk("t3_spike", 32'(held_sp), 32'b01);
      in_data  = 16'h0047;
      in_valid = 4'b0011;
      tick();
      in_valid = '0;
      for (int i = 0; i < 10; i++) begin
         chk("t3_hold_valid", 32'(evt_valid), 32'd1);
         chk("t3_hold_ch",    32'(evt_ch),    32'(held_ch));
         chk("t3_hold_spike", 32'(evt_spike), 32'(held_sp));
         chk("t3_blocked",    32'(in_ready[1:0]), 32'd0);
         tick();
      end
      evt_ready = 1'b1;
      tick();
      expect_evt("t3_after_a", 2'd1, 2'b10);
      expect_evt("t3_after_b", 2'd0, 2'b10);

      // emit_zero with threshold 0, full-range difference
      emit_zero = 1'b1;
      threshold = 4'd0;
      send(2, 4'd0);
      expect_evt("t4_zero", 2'd2, 2'b00);
      send(2, 4'd15);
      expect_evt("t4_full", 2'd2, 2'b10);
      emit_zero = 1'b0;

      // clear_prev on the same edge as an up-spike update of ch1
      threshold = 4'd3;
      send(1, 4'd12);
      tick();
      clear_prev = 1'b1;
      tick();
      clear_prev = 1'b0;
      chk("t5_valid", 32'(evt_valid), 32'd1);
      chk("t5_ch",    32'(evt_ch),    32'd1);
      chk("t5_spike", 32'(evt_spike), 32'b10);
      tick();
      send(1, 4'd12);
      expect_evt("t5_again", 2'd1, 2'b10);

      // asynchronous reset while an event waits
      evt_ready = 1'b0;
      send(3, 4'd9);
      wait_evt("t6_pre");
      send(0, 4'd5);
      chk("t6_pre_ready", 32'(in_ready[0]), 32'd0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(evt_valid), 32'd0);
      chk("t6_rst_ready", 32'(in_ready),  32'hF);
      #12;
      rst_n = 1'b1;
      evt_ready = 1'b1;
      tick();
      send(3, 4'd9);
      expect_evt("t6_post", 2'd3, 2'b10);

      // ena low holds off the grant but the buffer still captures
      ena = 1'b0;
      send(0, 4'd8);
      no_evt("t7_disabled", 6);
      chk("t7_ready", 32'(in_ready[0]), 32'd0);
      ena = 1'b1;
      expect_evt("t7_enabled", 2'd0, 2'b10);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
